// File: rtl/noc_pkg.sv
// Shared NoC definitions: default flit geometry, LFSR polynomial, traffic-generator
// FSM states and flit field extraction helpers.
package noc_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEST_W_DEF = 8;
  localparam logic [15:0] LFSR_POLY  = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } tg_state_e;

  function automatic logic [DEST_W_DEF-1:0] pkt_dest(input logic [DATA_W_DEF-1:0] flit);
    return flit[DATA_W_DEF-1 -: DEST_W_DEF];
  endfunction

  function automatic logic [DATA_W_DEF-DEST_W_DEF-1:0] pkt_payload(input logic [DATA_W_DEF-1:0] flit);
    return flit[DATA_W_DEF-DEST_W_DEF-1:0];
  endfunction

endpackage

// File: rtl/pe_traffic_gen_lfsr16.sv
// 16-bit right-shifting Galois LFSR; loads SEED on reset and advances when step is high.
module lfsr16
  import noc_pkg::*;
#(
  parameter logic [15:0] SEED = 16'h0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  output logic [15:0] state,
  output logic [15:0] state_nxt
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // state_nxt is the unconditional successor so callers can pre-compute the next packet
  assign state_nxt = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_POLY) : (lfsr_q >> 1);

  always_comb begin
    lfsr_d = lfsr_q;
    if (step) begin
      lfsr_d = state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/pe_traffic_gen.sv
// NoC processing-element traffic generator (LFSR-addressed packet injector) and
// always-ready sink with receive / misroute counters.
module pe_traffic_gen
  import noc_pkg::*;
#(
  parameter int unsigned ADDRESS   = 0,
  parameter int unsigned NUM_PE    = 16,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned DEST_W    = DEST_W_DEF,
  parameter int unsigned PKT_LIMIT = 100,
  parameter int unsigned INJ_GAP   = 0,
  parameter bit          SKIP_SELF = 1'b0,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_valid,
  output logic              o_data_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_valid,
  input  logic              i_data_ready,
  output logic              o_done,
  output logic [31:0]       o_tx_count,
  output logic [31:0]       o_rx_count,
  output logic [31:0]       o_rx_err_count
);

  localparam int unsigned NODE_W   = $clog2(NUM_PE);
  localparam int unsigned PAY_W    = DATA_W - DEST_W;
  localparam logic [15:0] SEED_X   = SEED ^ 16'(ADDRESS);
  localparam logic [15:0] SEED_EFF = (SEED_X == 16'h0000) ? 16'h0001 : SEED_X;
  localparam logic [31:0] PAY_BASE = 32'(PKT_LIMIT * ADDRESS);

  tg_state_e         state_q, state_d;
  logic [31:0]       tx_q, tx_d;
  logic [31:0]       seq_q, seq_d;
  logic [31:0]       gap_q, gap_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [31:0]       rx_q, rx_d;
  logic [31:0]       err_q, err_d;
  logic              lfsr_step;
  logic [15:0]       lfsr_cur;
  logic [15:0]       lfsr_nxt;
  logic              unused_payload;

  lfsr16 #(
    .SEED (SEED_EFF)
  ) u_lfsr (
    .clk       (clk),
    .rst_n     (rst),
    .step      (lfsr_step),
    .state     (lfsr_cur),
    .state_nxt (lfsr_nxt)
  );

  function automatic logic [DATA_W-1:0] build_flit(input logic [15:0] lfsr, input logic [31:0] seq);
    logic [DEST_W-1:0] dest;
    logic [31:0]       pay;
    dest = DEST_W'(lfsr[NODE_W-1:0]);
    if (SKIP_SELF && (dest == DEST_W'(ADDRESS))) begin
      dest[0] = ~dest[0];
    end
    pay = PAY_BASE + seq;
    return {dest, PAY_W'(pay)};
  endfunction

  // o_data is reloaded with the following packet at every transfer, so it is already
  // correct when a GAP ends; a restart rebuilds it because seq returns to zero.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    seq_d     = seq_q;
    gap_d     = gap_q;
    data_d    = data_q;
    lfsr_step = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          tx_d  = '0;
          seq_d = '0;
          if (PKT_LIMIT == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SEND;
            data_d  = build_flit(lfsr_cur, '0);
          end
        end
      end
      ST_SEND: begin
        if (i_data_ready) begin
          tx_d      = tx_q + 32'd1;
          seq_d     = seq_q + 32'd1;
          lfsr_step = 1'b1;
          data_d    = build_flit(lfsr_nxt, seq_q + 32'd1);
          if (tx_q + 32'd1 == 32'(PKT_LIMIT)) begin
            state_d = ST_DONE;
          end else if (INJ_GAP > 0) begin
            state_d = ST_GAP;
            gap_d   = '0;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == 32'(INJ_GAP - 1)) begin
          state_d = ST_SEND;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_d  = rx_q;
    err_d = err_q;
    if (i_data_valid) begin
      rx_d = rx_q + 32'd1;
      if (i_data[DATA_W-1 -: DEST_W] != DEST_W'(ADDRESS)) begin
        err_d = err_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      tx_q    <= '0;
      seq_q   <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      rx_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      seq_q   <= seq_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      rx_q    <= rx_d;
      err_q   <= err_d;
    end
  end

  assign unused_payload = ^i_data[PAY_W-1:0];

  assign o_data_ready   = 1'b1;
  assign o_data         = data_q;
  assign o_data_valid   = (state_q == ST_SEND);
  assign o_done         = (state_q == ST_DONE);
  assign o_tx_count     = tx_q;
  assign o_rx_count     = rx_q;
  assign o_rx_err_count = err_q;

endmodule

// File: doc/pe_traffic_gen.md
Name: pe_traffic_gen

Overview:
Synthesisable, parametrised traffic generator and sink for one NoC processing-element port.
- Injects a configurable number of packets `{dest, payload}` into the router with a valid/ready handshake.
- Destination is drawn from an LFSR; optional self-skip and a programmable inter-packet gap are supported.
- Always accepts ejected packets, counting received and misrouted ones for the bench and for on-chip status.

Parameters:
- ADDRESS, 0: this PE's node id.
- NUM_PE, 16: number of nodes; must be a power of two, ≥2.
- DATA_W, 32: flit width.
- DEST_W, 8: destination field width, held in flit[DATA_W-1 -: DEST_W].
- PKT_LIMIT, 100: packets sent per run.
- INJ_GAP, 0: idle cycles, with valid low, inserted after each accepted packet.
- SKIP_SELF, 0: 1 = never address self.
- SEED, 16'hACE1: LFSR seed; effective seed = SEED ^ ADDRESS, forced to 16'h0001 if zero.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous, active-low reset.
- i_start, input, 1: start pulse (sampled in IDLE/DONE).
- i_data, input, DATA_W: ejected flit from router.
- i_data_valid, input, 1: ejected flit valid.
- o_data_ready, output, 1: sink ready; tied 1.
- o_data, output, DATA_W: injected flit.
- o_data_valid, output, 1: injected flit valid.
- i_data_ready, input, 1: router accepts injected flit.
- o_done, output, 1: high while all PKT_LIMIT packets have been sent.
- o_tx_count, output, 32: packets accepted by router this run.
- o_rx_count, output, 32: flits received since reset.
- o_rx_err_count, output, 32: received flits whose dest field ≠ ADDRESS.

Behaviour:
- Reset (rst=0, asynchronous) clears the following, regardless of state, mid-packet included:
  - o_data_valid=0, o_data=0, o_done=0;
  - all counters=0, seq=0;
  - FSM=IDLE;
  - LFSR=effective seed.
- Transfer occurs on a rising clk edge with o_data_valid && i_data_ready.
- While valid && !ready, o_data and o_data_valid are held stable; no retraction.
- FSM states:
  - IDLE: valid=0. i_start → SEND.
  - SEND: valid=1. On transfer: tx_count+1, seq+1, LFSR steps once. Then:
    - tx_count+1==PKT_LIMIT → DONE;
    - else INJ_GAP>0 → GAP;
    - else stay in SEND with the next packet presented the next cycle (back-to-back, 1 packet/cycle).
  - GAP: valid=0 for exactly INJ_GAP cycles, then SEND.
  - DONE: valid=0, o_done=1. i_start clears tx_count, seq and o_done and goes to SEND. The LFSR is not reseeded.
- i_start outside IDLE/DONE is ignored.
- Packet presented in SEND:
  - dest = LFSR[log2(NUM_PE)-1:0], zero-extended to DEST_W.
  - If SKIP_SELF and dest==ADDRESS, dest ^= 1.
  - payload (low DATA_W-DEST_W bits) = PKT_LIMIT*ADDRESS + seq, truncated.
  - o_data is registered; it changes only on entry to SEND or after a transfer.
- LFSR: 16-bit Galois, right shift. If bit0=1, next = (lfsr>>1) ^ 16'hB400; else next = lfsr>>1.
- PKT_LIMIT=0: i_start goes directly to DONE with no packets.
- Receive side:
  - Every cycle with i_data_valid, rx_count+1.
  - If i_data[DATA_W-1 -: DEST_W] ≠ ADDRESS, rx_err_count+1.
  - Receive is independent of the FSM and active in all states.
- Counters wrap at 2^32.

Decomposition:
- Package noc_pkg holds:
  - DATA_W/DEST_W defaults;
  - LFSR_POLY=16'hB400;
  - the FSM state enum;
  - functions pkt_dest(flit) and pkt_payload(flit) for field extraction, shared with routers and the bench.
- Sub-module lfsr16 (seed load on reset, step enable, 16-bit state output).

Test Plan:
- Back-to-back send: ADDRESS=0, SEED=1, PKT_LIMIT=3, INJ_GAP=0, ready=1, i_start.
  - Required flits 0x01000000, 0x00000001, then dest=LFSR 0x5A00[3:0]=0, payload 2.
  - o_done=1 one cycle after the 3rd transfer; o_tx_count=3.
- Backpressure: i_data_ready=0 for 5 cycles mid-run → o_data stable and valid held. Release → exactly one transfer; no duplicate or skipped seq.
- Gap: INJ_GAP=2 → transfers spaced 3 cycles apart, valid=0 during the 2 gap cycles.
- Self-skip: SKIP_SELF=1, ADDRESS=5, PKT_LIMIT=1000 → no flit has dest 5; payloads 5000..5999 in order.
- Receive: 4 flits with dest=ADDRESS plus 2 with dest=ADDRESS+1 (some during backpressure) → o_rx_count=6, o_rx_err_count=2.
- Reset and restart:
  - Assert rst mid-SEND with valid=1 → valid drops immediately (asynchronous); all counters 0.
  - After release and i_start, the first flit matches the first post-reset flit.
  - i_start in DONE → a second run of PKT_LIMIT packets, o_done deasserted.
